// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: word width, HALT encoding and fetch FSM states.
// HALT handling is only active when INST_FETCH_HALT_DETECT_EN is defined.
package inst_fetch_pkg;

   localparam int unsigned INST_W = 32;
   localparam logic [INST_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bus bundle: instruction memory port, IF->ID handshake, EXE redirect.
// master = fetch unit, slave = memory/ID/EXE environment.
interface inst_fetch_if
   import inst_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) ();

   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic [INST_W-1:0] instruction;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic              redirect_en;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;

   modport master (
      output imem_en, imem_addr,
      input  imem_rdata,
      output instruction, inst_pc, inst_valid,
      input  inst_ready,
      input  redirect_en, redirect_pc,
      output halt
   );

   modport slave (
      input  imem_en, imem_addr,
      output imem_rdata,
      input  instruction, inst_pc, inst_valid,
      output inst_ready,
      output redirect_en, redirect_pc,
      input  halt
   );

endinterface

// File: rtl/inst_fetch_queue.sv
// 2-entry FIFO between imem read data and ID; flush has priority.
module inst_fetch_queue #(
   parameter int unsigned W = 42
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         head_valid,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         rd_q, rd_d, wr_q, wr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_pop, do_push;

   assign do_pop  = pop & (cnt_q != 2'd0);
   assign do_push = push & ((cnt_q != 2'd2) | do_pop);

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush) begin
         rd_d  = 1'b0;
         wr_d  = 1'b0;
         cnt_d = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
         end
         if (do_pop) rd_d = ~rd_q;
         cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_data  = mem_q[rd_q];
   assign head_valid = (cnt_q != 2'd0);
   assign count      = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, 1-cycle imem read, 2-entry queue to ID, EXE redirect.
// Define INST_FETCH_HALT_DETECT_EN to stop fetching at the HALT word.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst_n,
   inst_fetch_if.master bus
);

   localparam int unsigned QW = INST_W + ADDR_W;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              infl_q, infl_d;
   logic              live_q, live_d;

   logic [QW-1:0]     q_head;
   logic              q_valid;
   logic [1:0]        q_count;
   logic [INST_W-1:0] head_inst;
   logic [ADDR_W-1:0] head_pc;
   logic              push, valid, xfer, room, issue;
   logic              halt_push, halt_pop;

   assign head_inst = q_head[QW-1:ADDR_W];
   assign head_pc   = q_head[ADDR_W-1:0];

   assign push  = infl_q & ~bus.redirect_en;
   assign valid = q_valid & ~bus.redirect_en & (state_q != HALTED);
   assign xfer  = valid & bus.inst_ready;
   // a word leaving this cycle frees the slot the next read will land in
   assign room  = ({1'b0, q_count} + {2'b00, infl_q}) < (3'd2 + {2'b00, xfer});

`ifdef INST_FETCH_HALT_DETECT_EN
   assign halt_push = push & (bus.imem_rdata == HALT_WORD);
   assign halt_pop  = xfer & (state_q == DRAIN) & (head_inst == HALT_WORD);
`else
   assign halt_push = 1'b0;
   assign halt_pop  = 1'b0;
`endif

   // the word behind HALT is never read
   assign issue = live_q & (state_q == RUN) & ~bus.redirect_en
                & ~halt_push & room;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ipc_d   = ipc_q;
      infl_d  = issue;
      live_d  = 1'b1;
      if (bus.redirect_en) begin
         state_d = RUN;
         pc_d    = bus.redirect_pc;
         infl_d  = 1'b0;
      end else begin
         if (issue) begin
            pc_d  = pc_q + ADDR_W'(1);
            ipc_d = pc_q;
         end
         unique case (state_q)
            RUN:     if (halt_push) state_d = DRAIN;
            DRAIN:   if (halt_pop) state_d = HALTED;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         ipc_q   <= '0;
         infl_q  <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         infl_q  <= infl_d;
         live_q  <= live_d;
      end
   end

   inst_fetch_queue #(.W(QW)) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (bus.redirect_en),
      .push       (push),
      .push_data  ({bus.imem_rdata, ipc_q}),
      .pop        (xfer),
      .head_data  (q_head),
      .head_valid (q_valid),
      .count      (q_count)
   );

   assign bus.imem_en     = issue;
   assign bus.imem_addr   = pc_q;
   assign bus.instruction = head_inst;
   assign bus.inst_pc     = head_pc;
   assign bus.inst_valid  = valid;
   assign bus.halt        = (state_q == HALTED);

endmodule
